// File: rtl/hazard_ctrl_if.sv
// D-stage decode fields into the hazard unit and its stall/forward controls back out.
interface hazard_ctrl_if;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic       d_use_rs;
  logic       d_use_rt;
  logic       d_tuse;
  logic [4:0] d_wr_addr;
  logic [1:0] d_res;
  logic       d_md_start;
  logic       d_md_div;
  logic       d_md_use;
  logic       stall;
  logic [1:0] fwd_d_rs;
  logic [1:0] fwd_d_rt;
  logic [1:0] fwd_e_rs;
  logic [1:0] fwd_e_rt;
  logic       md_busy;

  modport master (
    output d_rs, d_rt, d_use_rs, d_use_rt, d_tuse, d_wr_addr, d_res,
           d_md_start, d_md_div, d_md_use,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy
  );

  modport slave (
    input  d_rs, d_rt, d_use_rs, d_use_rt, d_tuse, d_wr_addr, d_res,
           d_md_start, d_md_div, d_md_use,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: stall detection, D/E operand forwarding selects,
// and the multiply/divide busy counter.
module hazard_fwd_sel (
  input  logic [4:0] i_src,
  input  logic [4:0] i_m_wr,
  input  logic [1:0] i_m_res,
  input  logic [4:0] i_w_wr,
  input  logic [1:0] i_w_res,
  output logic [1:0] o_sel
);
  logic w_m_hit, w_w_hit;

  // Only an ALU result in M is forwardable; a load in M must wait until it reaches W.
  assign w_m_hit = (i_src != 5'd0) && (i_m_res == 2'b01) && (i_m_wr == i_src);
  assign w_w_hit = (i_src != 5'd0) && (i_w_res != 2'b00) && (i_w_wr == i_src);
  assign o_sel   = w_m_hit ? 2'b10 : (w_w_hit ? 2'b11 : 2'b01);
endmodule

module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_ctrl_if.slave  bus
);
  localparam int         NUM_OPS  = 2;
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_LD   = 2'b10;

  typedef struct packed {
    logic [4:0] wr;
    logic [1:0] res;
  } ent_t;

  ent_t                     r_e, r_m, r_w;
  logic [NUM_OPS-1:0][4:0]  r_e_src;
  logic                     r_e_md_start;
  logic                     r_e_md_div;
  logic [3:0]               r_md_cnt;

  logic [NUM_OPS-1:0][4:0]  w_d_src;
  logic [NUM_OPS-1:0]       w_d_use;
  logic [NUM_OPS-1:0]       w_op_stall;
  logic [NUM_OPS-1:0][1:0]  w_fwd_d;
  logic [NUM_OPS-1:0][1:0]  w_fwd_e;
  logic [1:0]               w_d_res;
  logic                     w_md_busy;
  logic                     w_md_stall;
  logic                     w_stall;

  function automatic logic f_writes(input ent_t e, input logic [4:0] r);
    return (e.res != RES_NONE) && (e.wr == r) && (r != 5'd0);
  endfunction

  // Operand index 0 is rs, 1 is rt.
  assign w_d_src = {bus.d_rt, bus.d_rs};
  assign w_d_use = {bus.d_use_rt, bus.d_use_rs};
  assign w_d_res = (bus.d_res == 2'b11) ? RES_NONE : bus.d_res;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    assign w_op_stall[g] = w_d_use[g] && (bus.d_tuse
      ? (f_writes(r_e, w_d_src[g]) && (r_e.res == RES_LD))
      : (f_writes(r_e, w_d_src[g]) ||
         (f_writes(r_m, w_d_src[g]) && (r_m.res == RES_LD))));

    hazard_fwd_sel u_fwd_d (
      .i_src   (w_d_src[g]),
      .i_m_wr  (r_m.wr),
      .i_m_res (r_m.res),
      .i_w_wr  (r_w.wr),
      .i_w_res (r_w.res),
      .o_sel   (w_fwd_d[g])
    );

    hazard_fwd_sel u_fwd_e (
      .i_src   (r_e_src[g]),
      .i_m_wr  (r_m.wr),
      .i_m_res (r_m.res),
      .i_w_wr  (r_w.wr),
      .i_w_res (r_w.res),
      .o_sel   (w_fwd_e[g])
    );
  end

  // A start sitting in E has not loaded the counter yet, so it blocks HI/LO users too.
  assign w_md_busy  = (r_md_cnt != 4'd0);
  assign w_md_stall = bus.d_md_use && (w_md_busy || r_e_md_start);
  assign w_stall    = (|w_op_stall) || w_md_stall;

  assign bus.stall    = w_stall;
  assign bus.fwd_d_rs = w_fwd_d[0];
  assign bus.fwd_d_rt = w_fwd_d[1];
  assign bus.fwd_e_rs = w_fwd_e[0];
  assign bus.fwd_e_rt = w_fwd_e[1];
  assign bus.md_busy  = w_md_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_e          <= '0;
      r_m          <= '0;
      r_w          <= '0;
      r_e_src      <= '0;
      r_e_md_start <= 1'b0;
      r_e_md_div   <= 1'b0;
      r_md_cnt     <= 4'd0;
    end else begin
      r_w <= r_m;
      r_m <= r_e;
      if (w_stall) begin
        r_e          <= '0;
        r_e_src      <= '0;
        r_e_md_start <= 1'b0;
        r_e_md_div   <= 1'b0;
      end else begin
        r_e.wr       <= bus.d_wr_addr;
        r_e.res      <= w_d_res;
        // Unused operand fields are zeroed so they can never pick up a forward.
        for (int i = 0; i < NUM_OPS; i++)
          r_e_src[i] <= w_d_use[i] ? w_d_src[i] : 5'd0;
        r_e_md_start <= bus.d_md_start;
        r_e_md_div   <= bus.d_md_div;
      end
      if (r_e_md_start)
        r_md_cnt <= r_e_md_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
      else if (r_md_cnt != 4'd0)
        r_md_cnt <= r_md_cnt - 4'd1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Vector table of D-stage instructions with expected hazard outputs, plus reset corner cases.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if bus();

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  localparam logic [1:0] RF = 2'b01;
  localparam logic [1:0] EM = 2'b10;
  localparam logic [1:0] MW = 2'b11;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       tuse;
    logic [4:0] wr;
    logic [1:0] res;
    logic [2:0] md;     // {start, div, use}
    logic [9:0] e_out;  // {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy}
  } vec_t;

  vec_t       tbl[$];
  logic [9:0] sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [9:0] O0;

  function automatic logic [9:0] o(input logic st, input logic [1:0] a, b, c, d,
                                   input logic busy);
    return {st, a, b, c, d, busy};
  endfunction

  function automatic vec_t mk(input logic [4:0] rs, rt, input logic urs, urt, tuse,
                              input logic [4:0] wr, input logic [1:0] res,
                              input logic [2:0] md, input logic [9:0] e);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.tuse = tuse;
    v.wr = wr; v.res = res; v.md = md; v.e_out = e;
    return v;
  endfunction

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask
  task automatic alu(input logic [4:0] wr, input logic [9:0] e);
    add(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, wr, 2'b01, 3'b000, e));
  endtask
  task automatic ld(input logic [4:0] wr, input logic [9:0] e);
    add(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, wr, 2'b10, 3'b000, e));
  endtask
  task automatic rd(input logic [4:0] rs, rt, input logic urs, urt, tuse,
                    input logic [9:0] e);
    add(mk(rs, rt, urs, urt, tuse, 5'd0, 2'b00, 3'b000, e));
  endtask
  task automatic nop(input logic [9:0] e);
    add(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 2'b00, 3'b000, e));
  endtask
  task automatic mdv(input logic [2:0] md, input logic [9:0] e);
    add(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 2'b00, md, e));
  endtask

  task automatic drive(input vec_t v);
    bus.d_rs = v.rs; bus.d_rt = v.rt;
    bus.d_use_rs = v.urs; bus.d_use_rt = v.urt; bus.d_tuse = v.tuse;
    bus.d_wr_addr = v.wr; bus.d_res = v.res;
    {bus.d_md_start, bus.d_md_div, bus.d_md_use} = v.md;
  endtask

  function automatic logic [9:0] outs();
    return {bus.stall, bus.fwd_d_rs, bus.fwd_d_rt, bus.fwd_e_rs, bus.fwd_e_rt, bus.md_busy};
  endfunction

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b (stall,fdrs,fdrt,fers,fert,busy)", nm, act, exp);
    end
  endtask

  initial begin
    O0 = o(1'b0, RF, RF, RF, RF, 1'b0);

    // ALU result consumed in E at distance 1 and 2
    alu(5'd8, O0);
    rd(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, O0);
    rd(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, o(1'b0, EM, RF, EM, RF, 1'b0));
    nop(o(1'b0, RF, RF, MW, RF, 1'b0)); nop(O0); nop(O0);
    // load-use in E: one bubble
    ld(5'd9, O0);
    rd(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, o(1'b1, RF, RF, RF, RF, 1'b0));
    rd(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, O0);
    nop(o(1'b0, RF, RF, MW, RF, 1'b0)); nop(O0); nop(O0);
    // ALU then branch compare in D
    alu(5'd4, O0);
    rd(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, o(1'b1, RF, RF, RF, RF, 1'b0));
    rd(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, o(1'b0, EM, RF, RF, RF, 1'b0));
    nop(o(1'b0, RF, RF, MW, RF, 1'b0)); nop(O0); nop(O0);
    // load then branch compare in D: two bubbles
    ld(5'd4, O0);
    rd(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, o(1'b1, RF, RF, RF, RF, 1'b0));
    rd(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, o(1'b1, RF, RF, RF, RF, 1'b0));
    rd(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, o(1'b0, MW, RF, RF, RF, 1'b0));
    nop(O0); nop(O0);
    // writes to $0 never match
    alu(5'd0, O0);
    add(mk(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 2'b10, 3'b000, O0));
    rd(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, O0);
    rd(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, O0);
    nop(O0);
    // rt path, mixed M/W sources
    alu(5'd5, O0); alu(5'd6, O0);
    rd(5'd6, 5'd5, 1'b1, 1'b1, 1'b1, o(1'b0, RF, EM, RF, RF, 1'b0));
    nop(o(1'b0, RF, RF, EM, MW, 1'b0)); nop(O0); nop(O0);
    // M wins over W for the same register
    alu(5'd7, O0); alu(5'd7, O0);
    rd(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, o(1'b0, EM, RF, RF, RF, 1'b0));
    rd(5'd7, 5'd7, 1'b1, 1'b1, 1'b1, o(1'b0, EM, EM, EM, RF, 1'b0));
    nop(o(1'b0, RF, RF, MW, MW, 1'b0)); nop(O0); nop(O0);
    // reserved result code behaves as no write
    add(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 2'b11, 3'b000, O0));
    rd(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, O0);
    rd(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, O0);
    rd(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, O0);
    nop(O0);
    // div then mflo: 11 stall cycles, 10 busy
    mdv(3'b111, O0);
    for (int i = 1; i <= 11; i++) mdv(3'b001, o(1'b1, RF, RF, RF, RF, i >= 2));
    mdv(3'b001, O0); nop(O0);
    // mult then mflo: 6 stall cycles, 5 busy
    mdv(3'b101, O0);
    for (int i = 1; i <= 6; i++) mdv(3'b001, o(1'b1, RF, RF, RF, RF, i >= 2));
    mdv(3'b001, O0); nop(O0);

    // reset state with a would-be hazard on the D inputs
    drive(mk(5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 5'd8, 2'b01, 3'b001, O0));
    #12;
    chk("reset_state", outs(), O0);
    drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 2'b00, 3'b000, O0));
    #11 reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      sb.push_back(tbl[i].e_out);
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(), sb.pop_front());
    end

    // reset asserted a few cycles into a divide, with ALU results in flight
    @(posedge clk); #1 drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 2'b00, 3'b111, O0));
    @(posedge clk); #1 drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 2'b01, 3'b000, O0));
    @(posedge clk); #1 drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 2'b01, 3'b000, O0));
    @(posedge clk); #1 drive(mk(5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 5'd0, 2'b00, 3'b001, O0));
    @(negedge clk);
    chk("div_busy_pre_rst", outs(), o(1'b1, EM, RF, RF, RF, 1'b1));
    #2 reset_n = 1'b0;
    #1 chk("rst_abort_now", outs(), O0);
    @(negedge clk);
    chk("rst_held", outs(), O0);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_mflo", outs(), O0);
    @(posedge clk); #1 drive(mk(5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 2'b00, 3'b000, O0));
    @(negedge clk);
    chk("post_rst_no_stale", outs(), O0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
